// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes and multi-cycle
// mul/div holds with a bounded wait, plus saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_branchTaken,
  input  logic             ex_mdStart,
  input  logic             md_done,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             bubble_mem,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MD_TIMEOUT) + 1;

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              wait_last;
  logic              md_issue;

  assign load_use  = ex_memRead && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign wait_last = (wait_cnt == WAIT_W'(MD_TIMEOUT - 1));
  assign md_issue  = !ex_branchTaken && ex_mdStart && !md_done;

  // Outputs are gated by rst_n so they read 0 the instant reset asserts.
  always_comb begin
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    flush_id   = 1'b0;
    flush_ex   = 1'b0;
    bubble_mem = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          if (ex_branchTaken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (ex_mdStart) begin
            if (!md_done) begin
              stall_if   = 1'b1;
              stall_id   = 1'b1;
              stall_ex   = 1'b1;
              bubble_mem = 1'b1;
            end
          end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!md_done) begin
            stall_if   = 1'b1;
            stall_id   = 1'b1;
            stall_ex   = 1'b1;
            bubble_mem = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      wait_cnt   <= '0;
      md_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (md_issue) begin
            state    <= MD_WAIT;
            wait_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state <= RUN;
          end else if (wait_last) begin
            state      <= RUN;
            md_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_pipeline_hazard_controller;

  localparam int TO  = 8;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          ex_memRead = 1'b0, ex_branchTaken = 1'b0;
  logic          ex_mdStart = 1'b0, md_done = 1'b0;
  logic          stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem;
  logic          md_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passes = 0;

  pipeline_hazard_controller #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_branchTaken(ex_branchTaken),
    .ex_mdStart(ex_mdStart), .md_done(md_done),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .bubble_mem(bubble_mem),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: whether a mul/div is outstanding, how many wait cycles it has used,
  // the sticky error, and plain integer event counts clipped at SAT.
  bit m_wait;
  int m_waited;
  bit m_to;
  int m_sc;
  int m_fc;

  // Expected {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem}.
  function automatic logic [5:0] exp_ctl();
    bit lu;
    lu = ex_memRead && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (!rst_n) return 6'b000000;
    if (m_wait) return md_done ? 6'b000000 : 6'b111001;
    if (ex_branchTaken) return 6'b000110;
    if (ex_mdStart) return md_done ? 6'b000000 : 6'b111001;
    if (lu) return 6'b110010;
    return 6'b000000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [5:0] e;
    if (!rst_n) begin
      m_wait = 0; m_waited = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      e = exp_ctl();
      if (e[5] && m_sc < SAT) m_sc++;
      if (e[2] && m_fc < SAT) m_fc++;
      if (m_wait) begin
        if (md_done) m_wait = 0;
        else if (m_waited == TO - 1) begin m_wait = 0; m_to = 1; end
        else m_waited++;
      end else if (!ex_branchTaken && ex_mdStart && !md_done) begin
        m_wait = 1; m_waited = 0;
      end
    end
  end

  function automatic logic [5:0] ctl();
    return {stall_if, stall_id, stall_ex, flush_id, flush_ex, bubble_mem};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_memRead = 0; ex_branchTaken = 0; ex_mdStart = 0; md_done = 0;
  endtask

  task automatic do_reset();
    #1 rst_n = 0;
    idle();
    step(); step();
    rst_n = 1;
  endtask

  initial begin
    // Per-cycle comparison against the model, sampled mid-cycle.
    fork
      forever begin
        @(negedge clk);
        chk("ctl", int'(ctl()), int'(exp_ctl()));
        chk("stall_cnt", int'(stall_cnt), m_sc);
        chk("flush_cnt", int'(flush_cnt), m_fc);
        chk("md_timeout", int'(md_timeout), int'(m_to));
      end
    join_none

    // Reset holds outputs at zero even with an issuing mul/div.
    idle();
    ex_mdStart = 1; ex_memRead = 1; ex_rd = 3; id_rs1 = 3;
    step(); step();
    chk("reset_ctl", int'(ctl()), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    idle();
    rst_n = 1;
    step();

    // Load-use on rs2: one stall cycle, bubble into EX.
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 1;
    @(negedge clk);
    chk("lu_ctl", int'(ctl()), 6'b110010);
    step(); idle();
    chk("lu_stall_cnt", int'(stall_cnt), 1);

    // Load to x0 never hazards.
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("x0_ctl", int'(ctl()), 0);
    step(); idle();

    // Branch wins over load-use.
    ex_branchTaken = 1; ex_memRead = 1; ex_rd = 7; id_rs1 = 7;
    @(negedge clk);
    chk("br_ctl", int'(ctl()), 6'b000110);
    step(); idle();
    chk("br_flush_cnt", int'(flush_cnt), 1);
    chk("br_stall_cnt", int'(stall_cnt), 1);

    // Mul/div issued, done on the 4th cycle after: 4 stall cycles.
    do_reset();
    ex_mdStart = 1;
    step(); idle();
    step(); step(); step();
    md_done = 1;
    @(negedge clk);
    chk("md_done_ctl", int'(ctl()), 0);
    step(); idle();
    chk("md_stall_cnt", int'(stall_cnt), 4);
    chk("md_no_timeout", int'(md_timeout), 0);

    // Timeout: issue cycle plus TO wait cycles stall, then back in RUN.
    do_reset();
    ex_mdStart = 1;
    step(); idle();
    for (int i = 0; i < 12; i++) step();
    chk("to_flag", int'(md_timeout), 1);
    chk("to_stall_cnt", int'(stall_cnt), 9);
    chk("to_run_ctl", int'(ctl()), 0);
    step(); step();
    chk("to_sticky", int'(md_timeout), 1);
    #1 rst_n = 0;
    #1 chk("to_cleared", int'(md_timeout), 0);
    step(); rst_n = 1;

    // Saturation: 20 load-use cycles clip at 15.
    ex_memRead = 1; ex_rd = 9; id_rs1 = 9;
    for (int i = 0; i < 20; i++) step();
    idle();
    chk("sat_stall_cnt", int'(stall_cnt), 15);

    // Reset in the middle of a mul/div wait aborts immediately.
    ex_mdStart = 1;
    step(); idle();
    step();
    chk("mdwait_ctl", int'(ctl()), 6'b111001);
    #1 rst_n = 0;
    #1 chk("abort_ctl", int'(ctl()), 0);
    chk("abort_stall_cnt", int'(stall_cnt), 0);
    step(); rst_n = 1;
    @(negedge clk);
    chk("post_abort_ctl", int'(ctl()), 0);
    step();

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_memRead = ($urandom_range(0, 2) == 0);
      ex_branchTaken = ($urandom_range(0, 5) == 0);
      ex_mdStart = ($urandom_range(0, 6) == 0);
      md_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
